// File: rtl/prog_clock_divider_if.sv
// Configuration/control bundle for the multi-channel clock divider.
// The design side uses the slave modport; the bench or host drives through the master modport.
interface prog_clock_divider_if #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2,
   parameter int CNT_W  = 16
);
   // cfg_we is a one-cycle valid with no ready; it is always consumed on the edge it is seen.
   // The outcome is visible on the following cycle: either cfg_err pulses or pending[ch] rises.
   logic [NUM_CH-1:0] en;
   logic              cfg_we;
   logic [CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic [CNT_W-1:0]  cfg_high;
   logic              cfg_err;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] OutputCLK;
   logic [NUM_CH-1:0] tick;

   modport master (
      output en, cfg_we, cfg_ch, cfg_div, cfg_high,
      input  cfg_err, pending, OutputCLK, tick
   );

   modport slave (
      input  en, cfg_we, cfg_ch, cfg_div, cfg_high,
      output cfg_err, pending, OutputCLK, tick
   );
endinterface

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with period-start ticks and a shadow
// config per channel that is applied only at period boundaries (or while disabled).
module prog_clock_divider #(
   parameter int NUM_CH       = 4,
   parameter int CH_W         = 2,
   parameter int CNT_W        = 16,
   parameter int DEFAULT_DIV  = 10,
   parameter int DEFAULT_HIGH = 5
) (
   input  logic               InputCLK,
   input  logic               rst,
   prog_clock_divider_if.slave bus
);

   localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] DEF_HIGH = CNT_W'(DEFAULT_HIGH);

   logic              wr_ok;
   logic              cfg_err_q, cfg_err_d;
   logic [NUM_CH-1:0] pending_vec;
   logic [NUM_CH-1:0] out_vec;
   logic [NUM_CH-1:0] tick_vec;

   // Validation guarantees HIGH < DIV, so DIV-HIGH can never underflow downstream.
   always_comb begin
      wr_ok = (32'(bus.cfg_ch) < 32'(NUM_CH)) &&
              (bus.cfg_div >= CNT_W'(2)) &&
              (bus.cfg_high != '0) &&
              (bus.cfg_high < bus.cfg_div);
      cfg_err_d = bus.cfg_we && !wr_ok;
   end

   always_ff @(posedge InputCLK or posedge rst) begin
      if (rst) cfg_err_q <= 1'b0;
      else     cfg_err_q <= cfg_err_d;
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] count_q, count_d;
      logic [CNT_W-1:0] act_div_q, act_div_d;
      logic [CNT_W-1:0] act_high_q, act_high_d;
      logic [CNT_W-1:0] sh_div_q, sh_div_d;
      logic [CNT_W-1:0] sh_high_q, sh_high_d;
      logic             pending_q, pending_d;
      logic             out_q, out_d;
      logic             tick_q, tick_d;
      logic             wr_hit;
      logic             wrap;
      logic             apply;

      always_comb begin
         wr_hit     = bus.cfg_we && wr_ok && (32'(bus.cfg_ch) == i);
         wrap       = bus.en[i] && (count_q == act_div_q - CNT_W'(1));
         apply      = pending_q && (wrap || !bus.en[i]);

         act_div_d  = act_div_q;
         act_high_d = act_high_q;
         if (apply) begin
            act_div_d  = sh_div_q;
            act_high_d = sh_high_q;
         end

         // A write coinciding with an apply lands in the shadow and stays pending.
         sh_div_d   = sh_div_q;
         sh_high_d  = sh_high_q;
         pending_d  = pending_q && !apply;
         if (wr_hit) begin
            sh_div_d  = bus.cfg_div;
            sh_high_d = bus.cfg_high;
            pending_d = 1'b1;
         end

         if (!bus.en[i] || wrap) count_d = '0;
         else                    count_d = count_q + CNT_W'(1);

         // Output level uses the config in force for the cycle being entered.
         out_d  = bus.en[i] && (count_d >= (act_div_d - act_high_d));
         tick_d = wrap;
      end

      always_ff @(posedge InputCLK or posedge rst) begin
         if (rst) begin
            count_q    <= '0;
            act_div_q  <= DEF_DIV;
            act_high_q <= DEF_HIGH;
            sh_div_q   <= DEF_DIV;
            sh_high_q  <= DEF_HIGH;
            pending_q  <= 1'b0;
            out_q      <= 1'b0;
            tick_q     <= 1'b0;
         end else begin
            count_q    <= count_d;
            act_div_q  <= act_div_d;
            act_high_q <= act_high_d;
            sh_div_q   <= sh_div_d;
            sh_high_q  <= sh_high_d;
            pending_q  <= pending_d;
            out_q      <= out_d;
            tick_q     <= tick_d;
         end
      end

      assign pending_vec[i] = pending_q;
      assign out_vec[i]     = out_q;
      assign tick_vec[i]    = tick_q;
   end

   assign bus.cfg_err   = cfg_err_q;
   assign bus.pending   = pending_vec;
   assign bus.OutputCLK = out_vec;
   assign bus.tick      = tick_vec;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider: default waveform, mid-period and on-wrap
// reconfiguration, write validation table, disable/apply, and async reset.
module tb_prog_clock_divider;
   localparam int NUM_CH = 4;
   localparam int CH_W   = 3;
   localparam int CNT_W  = 16;

   typedef struct {
      logic [CH_W-1:0]  ch;
      logic [CNT_W-1:0] div;
      logic [CNT_W-1:0] high;
      logic             exp_err;
   } wr_vec_t;

   logic InputCLK = 1'b0;
   logic rst      = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   phase0   = 0;
   int   n, hi;
   wr_vec_t vecs [7];

   prog_clock_divider_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

   prog_clock_divider #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W),
      .DEFAULT_DIV(10), .DEFAULT_HIGH(5)
   ) dut (
      .InputCLK(InputCLK),
      .rst     (rst),
      .bus     (bus.slave)
   );

   always #5 InputCLK = ~InputCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge InputCLK);
      #1;
      cyc++;
   endtask

   task automatic write_cfg(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] div,
                            input logic [CNT_W-1:0] high);
      bus.cfg_we   = 1'b1;
      bus.cfg_ch   = ch;
      bus.cfg_div  = div;
      bus.cfg_high = high;
      step();
      bus.cfg_we   = 1'b0;
   endtask

   task automatic wait_tick(input int ch);
      int k = 0;
      do begin
         step();
         k++;
      end while (bus.tick[ch] !== 1'b1 && k < 100);
      check($sformatf("wait_tick_ch%0d", ch), 32'(bus.tick[ch]), 32'd1);
   endtask

   // Steps until the next tick on ch; n = cycles taken, hi = samples with OutputCLK high.
   task automatic count_to_tick(input int ch, output int cnt, output int high_cnt);
      cnt = 0;
      high_cnt = 0;
      do begin
         step();
         cnt++;
         if (bus.OutputCLK[ch] === 1'b1) high_cnt++;
      end while (bus.tick[ch] !== 1'b1 && cnt < 100);
   endtask

   // From count 0 on every channel with 10/5 config: high after edges 5..9, tick after edge 10.
   task automatic first_period(input string tag);
      for (int k = 1; k <= 10; k++) begin
         step();
         check($sformatf("%s_tick_k%0d", tag, k), 32'(bus.tick),
               (k == 10) ? 32'hF : 32'h0);
         check($sformatf("%s_out_k%0d", tag, k), 32'(bus.OutputCLK),
               (k >= 5 && k <= 9) ? 32'hF : 32'h0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{ch: 3'd0, div: 16'd1, high: 16'd1, exp_err: 1'b1};
      vecs[1] = '{ch: 3'd1, div: 16'd5, high: 16'd0, exp_err: 1'b1};
      vecs[2] = '{ch: 3'd2, div: 16'd4, high: 16'd4, exp_err: 1'b1};
      vecs[3] = '{ch: 3'd4, div: 16'd8, high: 16'd3, exp_err: 1'b1};
      vecs[4] = '{ch: 3'd3, div: 16'd3, high: 16'd5, exp_err: 1'b1};
      vecs[5] = '{ch: 3'd0, div: 16'd10, high: 16'd5, exp_err: 1'b0};
      vecs[6] = '{ch: 3'd3, div: 16'd2, high: 16'd1, exp_err: 1'b0};

      bus.en = '0; bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0; bus.cfg_high = '0;

      // 1: reset state, then default 10/5 waveform on all channels
      #2 rst = 1'b1;
      #2;
      check("rst_out", 32'(bus.OutputCLK), 32'h0);
      check("rst_tick", 32'(bus.tick), 32'h0);
      check("rst_pending", 32'(bus.pending), 32'h0);
      check("rst_err", 32'(bus.cfg_err), 32'h0);
      @(negedge InputCLK) rst = 1'b0;
      step(); step();
      check("dis_out", 32'(bus.OutputCLK), 32'h0);
      bus.en = 4'hF;
      first_period("p1");
      phase0 = cyc % 10;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         count_to_tick(ch, n, hi);
         check($sformatf("def_period_ch%0d", ch), 32'(n), 32'd10);
         check($sformatf("def_high_ch%0d", ch), 32'(hi), 32'd5);
      end

      // 2: ch1 -> 3/1 written mid-period
      wait_tick(1);
      step(); step(); step();
      write_cfg(3'd1, 16'd3, 16'd1);
      check("t2_pending", 32'(bus.pending), 32'h2);
      check("t2_err", 32'(bus.cfg_err), 32'h0);
      count_to_tick(1, n, hi);
      check("t2_old_rest", 32'(n), 32'd6);
      check("t2_old_high", 32'(hi), 32'd5);
      check("t2_pending_clr", 32'(bus.pending), 32'h0);
      for (int r = 0; r < 2; r++) begin
         count_to_tick(1, n, hi);
         check("t2_new_period", 32'(n), 32'd3);
         check("t2_new_high", 32'(hi), 32'd1);
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (ch == 1) continue;
         wait_tick(ch);
         check($sformatf("t2_phase_ch%0d", ch), 32'(cyc % 10), 32'(phase0));
      end

      // 3: write validation table
      foreach (vecs[v]) begin
         write_cfg(vecs[v].ch, vecs[v].div, vecs[v].high);
         check($sformatf("t3_err_v%0d", v), 32'(bus.cfg_err), 32'(vecs[v].exp_err));
         if (vecs[v].exp_err)
            check($sformatf("t3_pend_v%0d", v), 32'(bus.pending), 32'h0);
         else
            check($sformatf("t3_pend_v%0d", v), 32'(bus.pending[vecs[v].ch]), 32'h1);
         step();
         check($sformatf("t3_err_clr_v%0d", v), 32'(bus.cfg_err), 32'h0);
      end
      wait_tick(0);
      check("t3_phase_ch0", 32'(cyc % 10), 32'(phase0));
      check("t3_pend_ch0", 32'(bus.pending[0]), 32'h0);
      count_to_tick(0, n, hi);
      check("t3_period_ch0", 32'(n), 32'd10);
      check("t3_high_ch0", 32'(hi), 32'd5);

      // 4: ch2 -> 7/2 written on the exact wrap edge
      while ((cyc + 1) % 10 != phase0) step();
      write_cfg(3'd2, 16'd7, 16'd2);
      check("t4_tick_at_write", 32'(bus.tick[2]), 32'h1);
      check("t4_pending", 32'(bus.pending[2]), 32'h1);
      count_to_tick(2, n, hi);
      check("t4_repeat_period", 32'(n), 32'd10);
      check("t4_repeat_high", 32'(hi), 32'd5);
      check("t4_pending_clr", 32'(bus.pending[2]), 32'h0);
      count_to_tick(2, n, hi);
      check("t4_new_period", 32'(n), 32'd7);
      check("t4_new_high", 32'(hi), 32'd2);

      // 5: disable ch3 while pending, then re-enable
      wait_tick(3);
      step(); step();
      write_cfg(3'd3, 16'd4, 16'd3);
      check("t5_pending", 32'(bus.pending[3]), 32'h1);
      bus.en = 4'h7;
      step();
      check("t5_dis_out", 32'(bus.OutputCLK[3]), 32'h0);
      check("t5_dis_tick", 32'(bus.tick[3]), 32'h0);
      check("t5_applied", 32'(bus.pending[3]), 32'h0);
      step(); step(); step();
      check("t5_dis_out_hold", 32'(bus.OutputCLK[3]), 32'h0);
      bus.en = 4'hF;
      count_to_tick(3, n, hi);
      check("t5_first_tick", 32'(n), 32'd4);
      check("t5_first_high", 32'(hi), 32'd3);
      count_to_tick(3, n, hi);
      check("t5_period", 32'(n), 32'd4);
      check("t5_high", 32'(hi), 32'd3);

      // 6: async reset mid-period with a pending write
      wait_tick(0);
      step(); step();
      write_cfg(3'd0, 16'd5, 16'd2);
      check("t6_pending_pre", 32'(bus.pending[0]), 32'h1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_out", 32'(bus.OutputCLK), 32'h0);
      check("t6_rst_tick", 32'(bus.tick), 32'h0);
      check("t6_rst_pending", 32'(bus.pending), 32'h0);
      check("t6_rst_err", 32'(bus.cfg_err), 32'h0);
      @(negedge InputCLK) rst = 1'b0;
      first_period("p6");
      count_to_tick(0, n, hi);
      check("t6_period", 32'(n), 32'd10);
      check("t6_high", 32'(hi), 32'd5);
      check("t6_pending", 32'(bus.pending), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
